iob_axistream_in_seq: RTL

IOB_AXISTREAM_IN_SEQ -- requirements
Module: iob_axistream_in_seq

---
 rtl/iob_axistream_in_seq.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/iob_axistream_in_seq.sv
// Sequencer that configures an IOb AXI-stream-in peripheral through its CSRs, drains nwords
// words into a valid/ready stream and disables it. Optional watchdog: IOB_AXISTREAM_IN_SEQ_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for start_i
// SRST1     | write SRST <- 1
// SRST0     | write SRST <- 0
// MODE      | write MODE <- latched mode
// NWORDS    | write NWORDS <- latched word count
// ENABLE    | write ENABLE <- 1
// RD_REQ    | issue read of DATA
// RD_RESP   | wait for read data
// PUSH      | hold word on the output stream until accepted
// DISABLE   | write ENABLE <- 0, then done
module iob_axistream_in_seq #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int SRST_ADDR   = 0,
  parameter int MODE_ADDR   = 1,
  parameter int NWORDS_ADDR = 4,
  parameter int ENABLE_ADDR = 8,
  parameter int DATA_ADDR   = 12,
  parameter int TIMEOUT     = 1023
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_i,
  input  logic                start_i,
  input  logic                mode_i,
  input  logic [DATA_W-1:0]   nwords_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic                iob_valid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  output logic                iob_rready_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                data_valid_o,
  input  logic                data_ready_i
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [ADDR_W-1:0] A_SRST   = ADDR_W'(SRST_ADDR);
  localparam logic [ADDR_W-1:0] A_MODE   = ADDR_W'(MODE_ADDR);
  localparam logic [ADDR_W-1:0] A_NWORDS = ADDR_W'(NWORDS_ADDR);
  localparam logic [ADDR_W-1:0] A_ENABLE = ADDR_W'(ENABLE_ADDR);
  localparam logic [ADDR_W-1:0] A_DATA   = ADDR_W'(DATA_ADDR);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SRST1,
    S_SRST0,
    S_MODE,
    S_NWORDS,
    S_ENABLE,
    S_RD_REQ,
    S_RD_RESP,
    S_PUSH,
    S_DISABLE
  } state_t;

  state_t state;
  state_t state_adv;
  state_t state_nxt;

  logic                mode_q;
  logic [DATA_W-1:0]   nwords_q;
  logic [DATA_W-1:0]   cnt;
  logic                timeout;

  logic                wr_en;
  logic                wr_wide;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_val;
  logic                rd_req;
  logic [STRB_W-1:0]   strb_base;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state <= S_IDLE;
    end else if (cke_i) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_adv    = state;
    wr_en        = 1'b0;
    wr_wide      = 1'b0;
    wr_addr      = '0;
    wr_val       = '0;
    rd_req       = 1'b0;
    iob_rready_o = 1'b0;
    data_valid_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) state_adv = S_SRST1;
      end
      S_SRST1: begin
        wr_en   = 1'b1;
        wr_addr = A_SRST;
        wr_val  = DATA_W'(1);
        if (iob_ready_i) state_adv = S_SRST0;
      end
      S_SRST0: begin
        wr_en   = 1'b1;
        wr_addr = A_SRST;
        if (iob_ready_i) state_adv = S_MODE;
      end
      S_MODE: begin
        wr_en   = 1'b1;
        wr_addr = A_MODE;
        wr_val  = DATA_W'(mode_q);
        if (iob_ready_i) state_adv = S_NWORDS;
      end
      S_NWORDS: begin
        wr_en   = 1'b1;
        wr_wide = 1'b1;
        wr_addr = A_NWORDS;
        wr_val  = nwords_q;
        if (iob_ready_i) state_adv = S_ENABLE;
      end
      S_ENABLE: begin
        wr_en   = 1'b1;
        wr_addr = A_ENABLE;
        wr_val  = DATA_W'(1);
        if (iob_ready_i) state_adv = (nwords_q != '0) ? S_RD_REQ : S_DISABLE;
      end
      S_RD_REQ: begin
        rd_req = 1'b1;
        if (iob_ready_i) state_adv = S_RD_RESP;
      end
      S_RD_RESP: begin
        iob_rready_o = 1'b1;
        if (iob_rvalid_i) state_adv = S_PUSH;
      end
      S_PUSH: begin
        data_valid_o = 1'b1;
        if (data_ready_i) state_adv = (cnt < nwords_q) ? S_RD_REQ : S_DISABLE;
      end
      S_DISABLE: begin
        wr_en   = 1'b1;
        wr_addr = A_ENABLE;
        if (iob_ready_i) state_adv = S_IDLE;
      end
      default: state_adv = S_IDLE;
    endcase
  end

  // Kept outside the FSM block so the watchdog can look at state_adv without a combinational loop.
  assign state_nxt = timeout ? S_IDLE : state_adv;

  assign busy_o      = (state != S_IDLE);
  assign iob_valid_o = wr_en | rd_req;
  assign iob_addr_o  = wr_en ? wr_addr : (rd_req ? A_DATA : '0);

  // Narrow CSRs sit in the byte lane selected by the low address bits.
  assign strb_base   = wr_wide ? '1 : STRB_W'(1);
  assign iob_wdata_o = wr_en ? (wr_val << {wr_addr[1:0], 3'b000}) : '0;
  assign iob_wstrb_o = wr_en ? (strb_base << wr_addr[1:0]) : '0;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      mode_q   <= 1'b0;
      nwords_q <= '0;
      cnt      <= '0;
      data_o   <= '0;
      done_o   <= 1'b0;
    end else if (cke_i) begin
      done_o <= (state == S_DISABLE) && iob_ready_i;
      if ((state == S_IDLE) && start_i) begin
        mode_q   <= mode_i;
        nwords_q <= nwords_i;
        cnt      <= '0;
      end
      if ((state == S_RD_RESP) && iob_rvalid_i) begin
        data_o <= iob_rdata_i;
        cnt    <= cnt + 1'b1;
      end
    end
  end

`ifdef IOB_AXISTREAM_IN_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_armed;

  // Down-counter reloaded on every state change; terminal count on a stalled cycle aborts.
  assign wd_armed = (state != S_IDLE) && (state != S_PUSH);
  assign timeout  = wd_armed && (state_adv == state) && (wd_cnt == '0);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wd_cnt  <= '0;
      error_o <= 1'b0;
    end else if (cke_i) begin
      if (state_nxt != state) begin
        wd_cnt <= WD_W'(TIMEOUT - 1);
      end else if (wd_cnt != '0) begin
        wd_cnt <= wd_cnt - 1'b1;
      end
      if (timeout) begin
        error_o <= 1'b1;
      end else if ((state == S_IDLE) && start_i) begin
        error_o <= 1'b0;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign error_o = 1'b0;
`endif

endmodule
